// File: rtl/counter_pkg.sv
// Shared state encoding and command codes for the counter sequencer.
package counter_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   localparam logic [1:0] CmdStart  = 2'b00;
   localparam logic [1:0] CmdStop   = 2'b01;
   localparam logic [1:0] CmdResume = 2'b10;
   localparam logic [1:0] CmdAbort  = 2'b11;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command channel of the counter sequencer: valid/ready handshake plus START operands.
interface counter_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd;
   logic [WIDTH-1:0] period;
   logic             auto_reload;

   modport master (output cmd_valid, cmd, period, auto_reload, input cmd_ready);
   modport slave (input cmd_valid, cmd, period, auto_reload, output cmd_ready);
endinterface

// File: rtl/sync_counter8.sv
// Synchronous toggle-chain counter: bit i toggles when enabled and all lower bits are 1.
module sync_counter8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] q_q;

   assign toggle[0] = en;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign toggle[i] = en & (&q_q[i-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_q ^ toggle;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven counter sequencer (IDLE/RUN/PAUSE/DONE) around a toggle-chain counter.
// Optional prescaler enabled by defining COUNTER_SEQUENCER_PRESCALE_EN.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   counter_sequencer_if.slave        cmd_bus,
   output logic [WIDTH-1:0]          q,
   output logic                      busy,
   output logic                      done,
   output logic                      tc
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             cmd_fire;
   logic             cmd_hit;
   logic             step_en;
   logic             cnt_en;
   logic             cnt_clr;

   assign cmd_bus.cmd_ready = rst_n;
   assign cmd_fire          = cmd_bus.cmd_valid & cmd_bus.cmd_ready;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   localparam logic [3:0] PrescMax = 4'(PRESCALE_DIV - 1);
   logic [3:0] presc_q, presc_d;
   logic       presc_clr;

   assign presc_clr = cmd_fire & ((cmd_bus.cmd == CmdStart) | (cmd_bus.cmd == CmdAbort));
   assign step_en   = (presc_q == PrescMax);

   // Advances only on RUN edges whose step is not pre-empted by a command.
   always_comb begin
      presc_d = presc_q;
      if (presc_clr) begin
         presc_d = '0;
      end else if (state_q == StRun && !cmd_hit) begin
         presc_d = step_en ? 4'd0 : presc_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
   end
`else
   logic unused_prescale_div;
   assign unused_prescale_div = (PRESCALE_DIV != 0);
   assign step_en = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;
      cmd_hit  = 1'b0;
      if (cmd_fire) begin
         unique case (cmd_bus.cmd)
            CmdStart: begin
               state_d  = StRun;
               period_d = cmd_bus.period;
               reload_d = cmd_bus.auto_reload;
               cnt_clr  = 1'b1;
               cmd_hit  = 1'b1;
            end
            CmdStop: if (state_q == StRun) begin
               state_d = StPause;
               cmd_hit = 1'b1;
            end
            CmdResume: if (state_q == StPause) begin
               state_d = StRun;
               cmd_hit = 1'b1;
            end
            CmdAbort: begin
               state_d = StIdle;
               cnt_clr = 1'b1;
               cmd_hit = 1'b1;
            end
            default: ;
         endcase
      end
      // An effective command discards the coincident step, including its TC.
      if (!cmd_hit && state_q == StRun && step_en) begin
         if (q == period_q) begin
            tc_d = 1'b1;
            if (reload_q) cnt_clr = 1'b1;
            else          state_d = StDone;
         end else begin
            cnt_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         period_q <= '0;
         reload_q <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   sync_counter8 #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .q    (q)
   );

   assign busy = (state_q == StRun) || (state_q == StPause);
   assign done = (state_q == StDone);
   assign tc   = tc_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer; prescale scenario when
// COUNTER_SEQUENCER_PRESCALE_EN is defined, unprescaled scenarios otherwise.
module tb_counter_sequencer;
   import counter_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] q;
   logic       busy;
   logic       done;
   logic       tc;
   int         vectors;
   int         miscompares;

   counter_sequencer_if #(.WIDTH(8)) bus ();

   counter_sequencer #(
      .WIDTH       (8),
      .PRESCALE_DIV(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cmd_bus(bus),
      .q      (q),
      .busy   (busy),
      .done   (done),
      .tc     (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [1:0] c, input logic [7:0] p, input logic r);
      bus.cmd_valid   = 1'b1;
      bus.cmd         = c;
      bus.period      = p;
      bus.auto_reload = r;
      @(negedge clk);
      bus.cmd_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd = 2'b00;
      bus.period = 8'd0;
      bus.auto_reload = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if (q !== 8'd0) begin miscompares++; $display("FAIL reset_q: got %0d want 0", q); end
      vectors++;
      if ({busy, done, tc} !== 3'b000) begin
         miscompares++; $display("FAIL reset_flags: got busy/done/tc=%b want 000", {busy, done, tc});
      end
      vectors++;
      if (bus.cmd_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_ready_low: got %b want 0", bus.cmd_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.cmd_ready !== 1'b1) begin
         miscompares++; $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_one_shot();
      send(CmdStart, 8'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (q !== 8'(i) || tc !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL one_shot_step%0d: got q=%0d tc=%b busy=%b want q=%0d tc=0 busy=1",
                     i, q, tc, busy, i);
         end
         @(negedge clk);
      end
      vectors++;
      if (q !== 8'd3 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL one_shot_tc: got q=%0d tc=%b done=%b busy=%b want q=3 tc=1 done=1 busy=0",
                  q, tc, done, busy);
      end
      @(negedge clk);
      vectors++;
      if (q !== 8'd3 || tc !== 1'b0 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL one_shot_hold: got q=%0d tc=%b done=%b want q=3 tc=0 done=1", q, tc, done);
      end
   endtask

   task automatic test_auto_reload();
      logic [7:0] exp_q [7] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
      logic       exp_tc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      send(CmdStart, 8'd2, 1'b1);
      for (int k = 0; k < 7; k++) begin
         vectors++;
         if (q !== exp_q[k] || tc !== exp_tc[k] || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_k%0d: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=1",
                     k, q, tc, busy, exp_q[k], exp_tc[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_period_zero();
      send(CmdStart, 8'd0, 1'b1);
      vectors++;
      if (q !== 8'd0 || tc !== 1'b0) begin
         miscompares++; $display("FAIL p0_reload_start: got q=%0d tc=%b want q=0 tc=0", q, tc);
      end
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if (q !== 8'd0 || tc !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL p0_reload_k%0d: got q=%0d tc=%b busy=%b want q=0 tc=1 busy=1",
                     k, q, tc, busy);
         end
      end
      @(negedge clk);
      send(CmdStart, 8'd0, 1'b0);
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || tc !== 1'b1 || q !== 8'd0) begin
         miscompares++;
         $display("FAIL p0_one_shot: got done=%b tc=%b q=%0d want done=1 tc=1 q=0", done, tc, q);
      end
   endtask

   task automatic test_pause_resume();
      send(CmdStart, 8'd20, 1'b0);
      repeat (5) @(negedge clk);
      vectors++;
      if (q !== 8'd5) begin miscompares++; $display("FAIL pause_pre: got q=%0d want 5", q); end
      send(CmdStop, 8'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (q !== 8'd5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL paused_c%0d: got q=%0d busy=%b want q=5 busy=1", i, q, busy);
         end
         @(negedge clk);
      end
      send(CmdResume, 8'd0, 1'b0);
      vectors++;
      if (q !== 8'd5) begin miscompares++; $display("FAIL resume_edge: got q=%0d want 5", q); end
      @(negedge clk);
      vectors++;
      if (q !== 8'd6) begin miscompares++; $display("FAIL resume_next: got q=%0d want 6", q); end
   endtask

   task automatic test_restart();
      int bad;
      send(CmdStart, 8'd7, 1'b0);
      repeat (7) @(negedge clk);
      vectors++;
      if (q !== 8'd7) begin miscompares++; $display("FAIL restart_pre: got q=%0d want 7", q); end
      // q equals the latched period here, so the START must swallow a would-be TC.
      send(CmdStart, 8'd255, 1'b0);
      vectors++;
      if (q !== 8'd0 || tc !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_edge: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=1", q, tc, busy);
      end
      bad = 0;
      for (int k = 1; k < 256; k++) begin
         @(negedge clk);
         if (q !== 8'(k) || tc !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++; $display("FAIL full_count: got %0d bad steps want 0", bad);
      end
      @(negedge clk);
      vectors++;
      if (q !== 8'd255 || tc !== 1'b1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL full_tc: got q=%0d tc=%b done=%b want q=255 tc=1 done=1", q, tc, done);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      send(CmdStart, 8'd20, 1'b0);
      repeat (9) @(negedge clk);
      vectors++;
      if (q !== 8'd9) begin miscompares++; $display("FAIL midrun_pre: got q=%0d want 9", q); end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (q !== 8'd0 || {busy, done, tc} !== 3'b000 || bus.cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_reset: got q=%0d busy/done/tc=%b ready=%b want 0 000 0",
                  q, {busy, done, tc}, bus.cmd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(CmdStart, 8'd1, 1'b0);
      vectors++;
      if (busy !== 1'b1 || q !== 8'd0) begin
         miscompares++;
         $display("FAIL first_cmd: got busy=%b q=%0d want busy=1 q=0", busy, q);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (done !== 1'b1 || q !== 8'd1) begin
         miscompares++; $display("FAIL midrun_done: got done=%b q=%0d want done=1 q=1", done, q);
      end
      send(CmdAbort, 8'd0, 1'b0);
      vectors++;
      if (q !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_done: got q=%0d done=%b busy=%b want q=0 done=0 busy=0",
                  q, done, busy);
      end
   endtask

   task automatic test_prescale();
      send(CmdStart, 8'd1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (q !== ((k >= 4) ? 8'd1 : 8'd0) || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL presc_k%0d: got q=%0d tc=%b want q=%0d tc=0",
                     k, q, tc, (k >= 4) ? 1 : 0);
         end
         @(negedge clk);
      end
      vectors++;
      if (q !== 8'd1 || tc !== 1'b1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL presc_tc: got q=%0d tc=%b done=%b want q=1 tc=1 done=1", q, tc, done);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
      test_prescale();
`else
      test_one_shot();
      @(negedge clk);
      test_auto_reload();
      test_period_zero();
      @(negedge clk);
      test_pause_resume();
      @(negedge clk);
      test_restart();
      test_reset_mid_run();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the counter width in bits.
REQ-002 SHALL have parameter PRESCALE_DIV, default 4, meaning clocks per count step when prescaling is compiled in (range 1..16).
REQ-003 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port CMD_VALID, input, 1, command offered.
REQ-006 SHALL have port CMD_READY, output, 1, command can be accepted.
REQ-007 SHALL have port CMD, input, 2, command code: 00 START, 01 STOP, 10 RESUME, 11 ABORT.
REQ-008 SHALL have port PERIOD, input, WIDTH, terminal count, sampled on START.
REQ-009 SHALL have port AUTO_RELOAD, input, 1, reload mode, sampled on START.
REQ-010 SHALL have port Q, output, WIDTH, current count.
REQ-011 SHALL have port BUSY, output, 1, high in RUN or PAUSE.
REQ-012 SHALL have port DONE, output, 1, high in DONE.
REQ-013 SHALL have port TC, output, 1, one-cycle terminal-count pulse.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-015 SHALL accept a command only on an edge where CMD_VALID and CMD_READY are both high; CMD_READY SHALL be 1 whenever RST_N is high.
REQ-016 SHALL, on START accepted in any state, latch PERIOD and AUTO_RELOAD, set Q to 0 and enter RUN at that edge.
REQ-017 SHALL, on STOP in RUN, enter PAUSE with Q held; STOP in any other state is ignored.
REQ-018 SHALL, on RESUME in PAUSE, enter RUN with Q unchanged; RESUME in any other state is ignored.
REQ-019 SHALL, on ABORT in any state, enter IDLE with Q set to 0.
REQ-020 SHALL, in RUN, take one count step per enabled edge; without prescaling every edge is enabled, so the first increment occurs on the edge after START.
REQ-021 SHALL, on a step with Q not equal to the latched period, set Q to Q+1.
REQ-022 SHALL, on a step with Q equal to the latched period, drive TC high for the next cycle only, and then either set Q to 0 and stay in RUN (AUTO_RELOAD=1), or hold Q and enter DONE (AUTO_RELOAD=0).
REQ-023 SHALL, with a latched period of 0, assert TC on every step in reload mode, and enter DONE on the first step in one-shot mode.
REQ-024 SHALL, with a latched period of 2^WIDTH-1, count through the full range and never wrap Q without TC.
REQ-025 SHALL give an accepted command priority over a coincident count step; the step is discarded and no TC is produced for it.
REQ-026 SHALL hold Q in IDLE, PAUSE and DONE.

Reset
REQ-027 SHALL, while RST_N is low, immediately force IDLE, Q=0, TC=0, BUSY=0, DONE=0 and CMD_READY=0, and clear the prescaler.
REQ-028 SHALL, when RST_N is asserted mid-RUN, lose the count; the first command SHALL be accepted on the first edge with RST_N high.

Configuration
REQ-029 SHALL, with COUNTER_SEQUENCER_PRESCALE_EN defined, include a 4-bit prescaler that enables a step every PRESCALE_DIV edges in RUN, is cleared on START or ABORT, and is held in PAUSE.
REQ-030 SHALL, without COUNTER_SEQUENCER_PRESCALE_EN, step on every RUN edge; PRESCALE_DIV is then unused.

Structure
REQ-031 SHALL take the state encoding type and the CMD code constants from the shared package counter_pkg.
REQ-032 SHALL instantiate sub-module sync_counter8, a synchronous toggle-chain counter with ports for enable, synchronous clear and Q output, as the count datapath; the sequencer owns all control logic.

Verification
REQ-033 SHALL cover: START with PERIOD=3, AUTO_RELOAD=0, no prescale -> Q=0,1,2,3; TC high one cycle after Q reaches 3; DONE=1; Q holds at 3.
REQ-034 SHALL cover: START with PERIOD=2, AUTO_RELOAD=1 -> Q=0,1,2,0,1,2; TC once per 3 steps; BUSY stays 1.
REQ-035 SHALL cover: STOP at Q=5, hold for 10 cycles, then RESUME -> Q stays 5 while paused, then continues to 6.
REQ-036 SHALL cover: START reissued at Q=7 with PERIOD=255 -> Q=0 at the accepting edge, with no TC; then a full count to 255 followed by TC.
REQ-037 SHALL cover: RST_N pulsed low mid-RUN at Q=9 -> outputs reach reset values without a clock edge; ABORT in DONE returns to IDLE with Q=0.
REQ-038 SHALL cover: with COUNTER_SEQUENCER_PRESCALE_EN defined and PRESCALE_DIV=4, PERIOD=1 -> Q changes every 4 clocks; TC follows the 2nd step.
